uart_rx_fifo: RTL



---
 rtl/uart_rx_fifo.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead byte FIFO; head byte visible the cycle after the stop-bit push.
// No backpressure on the line: a byte arriving while full (without a same-cycle pop) is dropped and flagged.
module uart_rx_fifo #(
    parameter int CLK_PER_HALF_BIT = 520,
    parameter int DEPTH_LOG2       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    input  logic                  rd_en,
    input  logic                  clr_err,
    output logic [7:0]            r_data,
    output logic                  receiver_valid,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  ferr,
    output logic                  overrun
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = $clog2(2 * CLK_PER_HALF_BIT);
    localparam logic [CNT_W-1:0]    HALF_LAST = CNT_W'(CLK_PER_HALF_BIT - 1);
    localparam logic [CNT_W-1:0]    BIT_LAST  = CNT_W'(2 * CLK_PER_HALF_BIT - 1);
    localparam logic [DEPTH_LOG2:0] FULL_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                state_q, state_d;
    logic                  rx_meta_q, rx_meta_d;
    logic                  rxs_q, rxs_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            idx_q, idx_d;
    logic [7:0]            shift_q, shift_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ferr_q, ferr_d;
    logic                  overrun_q, overrun_d;
    logic [7:0]            mem_q [DEPTH];
    logic [7:0]            mem_d [DEPTH];

    logic push;
    logic frame_err;
    logic full;
    logic pop;
    logic push_ok;
    logic drop;

    always_comb begin
        rx_meta_d = rxd;
        rxs_d     = rx_meta_q;
    end

    // Receive FSM: all counting restarts at zero on every state change.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rxs_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = rxs_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxs_q;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BREAK: begin
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // When full, a same-cycle pop vacates the head slot, which is exactly where wr_ptr points.
    always_comb begin
        full      = (count_q == FULL_CNT);
        pop       = rd_en && (count_q != '0);
        push_ok   = push && (!full || pop);
        drop      = push && full && !pop;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        mem_d     = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ferr_d    = (ferr_q && !clr_err) || frame_err;
        overrun_d = (overrun_q && !clr_err) || drop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            shift_q   <= 8'h00;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
            mem_q     <= '{default: 8'h00};
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx_meta_d;
            rxs_q     <= rxs_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ferr_q    <= ferr_d;
            overrun_q <= overrun_d;
            mem_q     <= mem_d;
        end
    end

    assign receiver_valid = (count_q != '0);
    assign r_data         = receiver_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign count          = count_q;
    assign ferr           = ferr_q;
    assign overrun        = overrun_q;

endmodule
